rf_access_sched: RTL and testbench

Sequencer and round-robin arbiter for the 32x32 register file (`rf_32`). It lets NUM_REQ requesters share the file's single strobe-driven access port, for example the pipeline decode/writeback stage and a debug or loader unit. Each access goes out as a one-cycle `start` strobe, waits for `finish`, and returns the captured read data on a shared response bus tagged with the requester ID.

---
 rtl/rf_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/rf_access_sched.sv | 192 +++++++++++++++++++
 tb/tb_rf_access_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file access scheduler.
package rf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int REG_SIZE_DEF   = 32;
    localparam int INDEX_SIZE_DEF = 5;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               hit
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        c   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!hit && req[c]) begin
                hit    = 1'b1;
                gnt[c] = 1'b1;
                idx    = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/rf_access_sched.sv
// Round-robin sequencer sharing the register file's start/finish port among NUM_REQ requesters.
// Optional WAIT watchdog with error response: define RF_SCHED_TIMEOUT_EN.
module rf_access_sched
    import rf_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int REG_SIZE       = REG_SIZE_DEF,
    parameter int INDEX_SIZE     = INDEX_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*INDEX_SIZE-1:0] req_read_addr_s,
    input  logic [NUM_REQ*INDEX_SIZE-1:0] req_read_addr_t,
    input  logic [NUM_REQ*INDEX_SIZE-1:0] req_write_addr,
    input  logic [NUM_REQ-1:0]            req_write_enabled,
    input  logic [NUM_REQ*REG_SIZE-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rsp_valid,
    output logic [2:0]                    rsp_id,
    output logic [REG_SIZE-1:0]           rsp_outA,
    output logic [REG_SIZE-1:0]           rsp_outB,
    output logic                          rsp_error,
    output logic                          rf_start,
    output logic [INDEX_SIZE-1:0]         rf_read_addr_s,
    output logic [INDEX_SIZE-1:0]         rf_read_addr_t,
    output logic [INDEX_SIZE-1:0]         rf_write_addr,
    output logic                          rf_write_enabled,
    output logic [REG_SIZE-1:0]           rf_write_data,
    input  logic                          rf_finish,
    input  logic [REG_SIZE-1:0]           rf_outA,
    input  logic [REG_SIZE-1:0]           rf_outB
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t state, state_next;
    logic [ID_W-1:0]       ptr, ptr_next, win, hold_id, rsp_id_q;
    logic [NUM_REQ-1:0]    arb_gnt, gnt_q;
    logic                  hit, load, capture;
    logic [INDEX_SIZE-1:0] sel_s, sel_t, sel_w, hold_s, hold_t, hold_w;
    logic                  sel_we, hold_we;
    logic [REG_SIZE-1:0]   sel_data, hold_data, rsp_a, rsp_b;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (win),
        .hit (hit)
    );

    // A write to r0 is suppressed here so the read half of the access still goes out.
    always_comb begin
        sel_s    = req_read_addr_s[int'(win)*INDEX_SIZE +: INDEX_SIZE];
        sel_t    = req_read_addr_t[int'(win)*INDEX_SIZE +: INDEX_SIZE];
        sel_w    = req_write_addr[int'(win)*INDEX_SIZE +: INDEX_SIZE];
        sel_data = req_write_data[int'(win)*REG_SIZE +: REG_SIZE];
        sel_we   = req_write_enabled[win] && (sel_w != '0);
        ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end

`ifdef RF_SCHED_TIMEOUT_EN
    localparam logic [3:0] WD_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] wd_cnt;
    logic       expire, err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (state == START)
            wd_cnt <= '0;
        else if (state == WAIT)
            wd_cnt <= wd_cnt + 4'd1;
    end
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
`ifdef RF_SCHED_TIMEOUT_EN
        expire     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (hit) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (rf_finish) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
`ifdef RF_SCHED_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                if (hit) begin
                    load       = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            gnt_q     <= '0;
            hold_id   <= '0;
            hold_s    <= '0;
            hold_t    <= '0;
            hold_w    <= '0;
            hold_we   <= 1'b0;
            hold_data <= '0;
            rsp_id_q  <= '0;
            rsp_a     <= '0;
            rsp_b     <= '0;
`ifdef RF_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            gnt_q <= '0;
            if (load) begin
                ptr       <= ptr_next;
                gnt_q     <= arb_gnt;
                hold_id   <= win;
                hold_s    <= sel_s;
                hold_t    <= sel_t;
                hold_w    <= sel_w;
                hold_we   <= sel_we;
                hold_data <= sel_data;
            end
            if (capture) begin
                rsp_id_q <= hold_id;
                rsp_a    <= rf_outA;
                rsp_b    <= rf_outB;
`ifdef RF_SCHED_TIMEOUT_EN
                err_q    <= 1'b0;
`endif
            end
`ifdef RF_SCHED_TIMEOUT_EN
            if (expire) begin
                rsp_id_q <= hold_id;
                rsp_a    <= '0;
                rsp_b    <= '0;
                err_q    <= 1'b1;
            end
`endif
        end
    end

`ifdef RF_SCHED_TIMEOUT_EN
    assign rsp_error = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign rsp_error      = 1'b0;
`endif

    assign gnt              = gnt_q;
    assign rf_start         = (state == START);
    assign rsp_valid        = (state == RESP);
    assign rsp_id           = 3'(rsp_id_q);
    assign rsp_outA         = rsp_a;
    assign rsp_outB         = rsp_b;
    assign rf_read_addr_s   = hold_s;
    assign rf_read_addr_t   = hold_t;
    assign rf_write_addr    = hold_w;
    assign rf_write_enabled = hold_we;
    assign rf_write_data    = hold_data;

endmodule

// File: tb/tb_rf_access_sched.sv
// Directed bench for rf_access_sched with a small register-file model; covers the watchdog build too.
module tb_rf_access_sched;

    localparam int NR = 2;
    localparam int RS = 32;
    localparam int IS = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NR-1:0]    req;
    logic [NR*IS-1:0] req_read_addr_s, req_read_addr_t, req_write_addr;
    logic [NR-1:0]    req_write_enabled;
    logic [NR*RS-1:0] req_write_data;
    logic [NR-1:0]    gnt;
    logic             rsp_valid, rsp_error, rf_start, rf_write_enabled, rf_finish;
    logic [2:0]       rsp_id;
    logic [RS-1:0]    rsp_outA, rsp_outB, rf_write_data, rf_outA, rf_outB;
    logic [IS-1:0]    rf_read_addr_s, rf_read_addr_t, rf_write_addr;
    logic             stall;

    int passed = 0;
    int total  = 0;
    int bad;

    logic [31:0] mem [32];

    rf_access_sched #(.NUM_REQ(NR), .REG_SIZE(RS), .INDEX_SIZE(IS), .TIMEOUT_CYCLES(15)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req               (req),
        .req_read_addr_s   (req_read_addr_s),
        .req_read_addr_t   (req_read_addr_t),
        .req_write_addr    (req_write_addr),
        .req_write_enabled (req_write_enabled),
        .req_write_data    (req_write_data),
        .gnt               (gnt),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .rsp_outA          (rsp_outA),
        .rsp_outB          (rsp_outB),
        .rsp_error         (rsp_error),
        .rf_start          (rf_start),
        .rf_read_addr_s    (rf_read_addr_s),
        .rf_read_addr_t    (rf_read_addr_t),
        .rf_write_addr     (rf_write_addr),
        .rf_write_enabled  (rf_write_enabled),
        .rf_write_data     (rf_write_data),
        .rf_finish         (rf_finish),
        .rf_outA           (rf_outA),
        .rf_outB           (rf_outB)
    );

    always #5 clock = ~clock;

    // Register file model: reads old contents and writes on the start strobe; finish idles high.
    assign rf_finish = ~stall;
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[3]  <= 32'h11;
            mem[4]  <= 32'h22;
            rf_outA <= 32'h0;
            rf_outB <= 32'h0;
        end else if (rf_start) begin
            rf_outA <= mem[rf_read_addr_s];
            rf_outB <= mem[rf_read_addr_t];
            if (rf_write_enabled) mem[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_slot(input int i, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] w, input logic we, input logic [31:0] d);
        req_read_addr_s[i*IS +: IS] = s;
        req_read_addr_t[i*IS +: IS] = t;
        req_write_addr[i*IS +: IS]  = w;
        req_write_enabled[i]        = we;
        req_write_data[i*RS +: RS]  = d;
    endtask

    initial begin
        logic [1:0] exp_g;
        reset_n = 1'b0;
        stall = 1'b0;
        req = '0;
        req_read_addr_s = '0;
        req_read_addr_t = '0;
        req_write_addr = '0;
        req_write_enabled = '0;
        req_write_data = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rf_start", 32'(rf_start), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'h0);
        check("rst_rf_we", 32'(rf_write_enabled), 32'h0);
        check("rst_rsp_outA", rsp_outA, 32'h0);
        reset_n = 1'b1;
        tick();

        // Single access: read r3/r4, write r5
        set_slot(0, 5'd3, 5'd4, 5'd5, 1'b1, 32'hDEADBEEF);
        req = 2'b01;
        check("s1_idle_gnt", 32'(gnt), 32'h0);
        tick();
        check("s1_gnt", 32'(gnt), 32'h1);
        check("s1_start", 32'(rf_start), 32'h1);
        check("s1_addr_s", 32'(rf_read_addr_s), 32'd3);
        check("s1_addr_t", 32'(rf_read_addr_t), 32'd4);
        check("s1_waddr", 32'(rf_write_addr), 32'd5);
        check("s1_we", 32'(rf_write_enabled), 32'h1);
        check("s1_wdata", rf_write_data, 32'hDEADBEEF);
        req = 2'b00;
        tick();
        check("s1_wait_start", 32'(rf_start), 32'h0);
        check("s1_wait_gnt", 32'(gnt), 32'h0);
        check("s1_wait_valid", 32'(rsp_valid), 32'h0);
        check("s1_wait_addr_s", 32'(rf_read_addr_s), 32'd3);
        tick();
        check("s1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("s1_rsp_id", 32'(rsp_id), 32'h0);
        check("s1_outA", rsp_outA, 32'h11);
        check("s1_outB", rsp_outB, 32'h22);
        check("s1_error", 32'(rsp_error), 32'h0);
        tick();
        check("s1_idle_valid", 32'(rsp_valid), 32'h0);

        // Read back r5
        set_slot(0, 5'd5, 5'd3, 5'd0, 1'b0, 32'h0);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        check("rb_valid", 32'(rsp_valid), 32'h1);
        check("rb_outA", rsp_outA, 32'hDEADBEEF);
        check("rb_outB", rsp_outB, 32'h11);
        tick();

        // Write to r0 from requester 1 (ptr is 1 here)
        set_slot(1, 5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFFFFFF);
        req = 2'b10;
        tick();
        check("wz_gnt", 32'(gnt), 32'h2);
        check("wz_we_start", 32'(rf_write_enabled), 32'h0);
        req = 2'b00;
        tick();
        check("wz_we_wait", 32'(rf_write_enabled), 32'h0);
        tick();
        check("wz_valid", 32'(rsp_valid), 32'h1);
        check("wz_id", 32'(rsp_id), 32'h1);
        check("wz_outA", rsp_outA, 32'h0);
        check("wz_outB", rsp_outB, 32'hDEADBEEF);
        tick();

        // Contention: both held, grants alternate, one access per 3 cycles
        set_slot(0, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0);
        set_slot(1, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0);
        req = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_g = 2'b00;
            if (k % 3 == 1) exp_g = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("ct_gnt_c%0d", k), 32'(gnt), 32'(exp_g));
            check($sformatf("ct_valid_c%0d", k), 32'(rsp_valid), (k % 3 == 0) ? 32'h1 : 32'h0);
            if (k % 3 == 0) begin
                check($sformatf("ct_id_c%0d", k), 32'(rsp_id), 32'(((k / 3) - 1) % 2));
                check($sformatf("ct_outA_c%0d", k), rsp_outA,
                      (((k / 3) - 1) % 2 == 1) ? 32'h22 : 32'h11);
            end
            if (k == 10) req = 2'b00;
        end
        tick();
        check("ct_end_valid", 32'(rsp_valid), 32'h0);
        check("ct_end_gnt", 32'(gnt), 32'h0);

        // Reset asserted in WAIT
        set_slot(0, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
        req = 2'b01;
        stall = 1'b1;
        tick();
        req = 2'b00;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("rw_start", 32'(rf_start), 32'h0);
        check("rw_gnt", 32'(gnt), 32'h0);
        check("rw_valid", 32'(rsp_valid), 32'h0);
        check("rw_addr_s", 32'(rf_read_addr_s), 32'h0);
        tick();
        reset_n = 1'b1;
        stall = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid) bad++;
        end
        check("rw_no_stale_rsp", 32'(bad), 32'h0);
        set_slot(1, 5'd4, 5'd3, 5'd0, 1'b0, 32'h0);
        req = 2'b10;
        tick();
        check("rw_gnt1", 32'(gnt), 32'h2);
        req = 2'b00;
        tick();
        tick();
        check("rw_rsp_id", 32'(rsp_id), 32'h1);
        check("rw_outA", rsp_outA, 32'h22);
        tick();

        // Reset asserted in START; ptr must return to 0
        req = 2'b01;
        tick();
        req = 2'b00;
        check("rs_gnt_before", 32'(gnt), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rs_gnt", 32'(gnt), 32'h0);
        check("rs_start", 32'(rf_start), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        req = 2'b11;
        tick();
        check("rs_ptr_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        tick();
        check("rs_rsp_id", 32'(rsp_id), 32'h0);
        tick();

        // rf_finish held low
        set_slot(0, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
        stall = 1'b1;
        req = 2'b01;
        tick();
        req = 2'b00;
`ifdef RF_SCHED_TIMEOUT_EN
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (rsp_valid) bad++;
        end
        check("to_early_rsp", 32'(bad), 32'h0);
        tick();
        check("to_valid", 32'(rsp_valid), 32'h1);
        check("to_error", 32'(rsp_error), 32'h1);
        check("to_outA", rsp_outA, 32'h0);
        check("to_outB", rsp_outB, 32'h0);
        stall = 1'b0;
        tick();
        check("to_idle_valid", 32'(rsp_valid), 32'h0);
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (rsp_valid) bad++;
        end
        check("st_no_rsp", 32'(bad), 32'h0);
        stall = 1'b0;
        tick();
        check("st_valid", 32'(rsp_valid), 32'h1);
        check("st_error", 32'(rsp_error), 32'h0);
        check("st_outA", rsp_outA, 32'h11);
        check("st_outB", rsp_outB, 32'h22);
        tick();
        check("st_idle_valid", 32'(rsp_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
